risc16_mem_loader: RTL and testbench
====================================

Name: risc16_mem_loader

Overview:
- Boot-time program loader that drives the write side of the RiSC16 word memory.
- Accepts a byte stream over a valid/ready handshake and assembles 16-bit words, high byte first.
- Writes the words sequentially from BASE_ADDR, then checks a trailing additive checksum.
- Holds `busy` while loading so the top level can keep the core in reset until `done`.

Parameters:
- WORD_LENGTH, 16, memory word width; the block is defined only for 16 (two bytes per word).
- MEM_SIZE, 65536, number of memory words; used for the length bound check.
- BASE_ADDR, 0, first memory address written.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin a load; sampled only in IDLE or DONE.
- in_byte  in  8  stream byte.
- in_valid  in  1  in_byte is valid.
- in_ready  out  1  loader accepts in_byte this cycle.
- mem_address  out  WORD_LENGTH  memory address.
- mem_data_out  out  WORD_LENGTH  word to write; connects to memory dataIn.
- mem_write_en  out  1  memory write enable.
- busy  out  1  load in progress.
- done  out  1  load finished; level signal.
- error  out  1  checksum mismatch or length overflow; valid while done=1.
- words_written  out  WORD_LENGTH  count of words written in the current or last load.

Behaviour:
- **Reset:** rst=1 at posedge sets state=IDLE and every output, counter and checksum to 0. Reset mid-load aborts the load; memory words already written are left untouched.
- **Handshake:** a byte is accepted at a posedge with in_valid&&in_ready. in_ready=1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK_HI, CHK_LO. in_valid is ignored in all other states. Gaps in in_valid just hold the state.
- **Stream format:** length word (hi, lo), then N data words (hi, lo each), then checksum word (hi, lo).
- **Outputs are registered:** mem_* change only on posedge, so they are stable at the memory's negedge write.
- **FSM transitions:**
  - IDLE: start → LEN_HI; clears words_written, the checksum accumulator, done and error; busy=1.
  - LEN_HI → LEN_LO on accept; the byte goes to len[15:8].
  - LEN_LO on accept:
    - len > MEM_SIZE-BASE_ADDR → DONE with error=1; no writes.
    - len==0 → CHK_HI.
    - otherwise → DATA_HI.
  - DATA_HI → DATA_LO on accept; the byte is latched into the word's high byte.
  - DATA_LO on accept → WRITE.
  - WRITE, exactly one cycle:
    - mem_write_en=1, mem_address=BASE_ADDR+words_written, mem_data_out=assembled word, in_ready=0.
    - At the next posedge: mem_write_en=0, words_written+1, the checksum accumulates the word (mod 2^16).
    - Then → CHK_HI if words_written+1==len, else → DATA_HI.
  - CHK_HI → CHK_LO on accept.
  - CHK_LO on accept → DONE; error = (received checksum != accumulator).
  - DONE: busy=0, done=1. start → LEN_HI with done and error cleared; otherwise hold.
- **Start rules:** start is ignored while busy.
- **Per-word cost:** 3 cycles minimum per word (two byte accepts plus WRITE).
- **Outside WRITE:** mem_write_en=0; mem_address and mem_data_out hold their last values.
- **No wrap-around:** the length check guarantees mem_address never exceeds MEM_SIZE-1. len==MEM_SIZE-BASE_ADDR is legal and fills to the top of memory.
- **Simultaneous events:** rst has priority over start and over byte accepts.

Test Plan:
1. **Normal load.** BASE_ADDR=0x0100; start, then stream 00 03 12 34 AB CD 00 01 BE 02 with continuous valid.
   - Writes 0x1234@0x0100, 0xABCD@0x0101, 0x0001@0x0102, one mem_write_en pulse each.
   - in_ready=0 on each WRITE cycle.
   - Ends with done=1, error=0, words_written=3, busy=0.
2. **Bad checksum.** Same stream with checksum bytes BE 03.
   - Same three writes occur.
   - Ends with done=1, error=1.
3. **Zero length.** Stream 00 00 00 00.
   - No mem_write_en pulse.
   - Ends with done=1, error=0, words_written=0.
   - Repeat with checksum 00 01: ends with error=1.
4. **Length overflow.** MEM_SIZE=16, BASE_ADDR=14; stream length 00 03.
   - DONE immediately after the length low byte, with error=1 and no writes.
   - Length 00 02 instead writes addresses 14 and 15, and the load completes normally.
5. **Gaps and ignored input.** Insert random 0–3 cycle in_valid gaps in scenario 1, and assert in_valid during WRITE cycles.
   - Same memory contents and result as scenario 1.
   - No byte is consumed during WRITE.
6. **Reset and restart.** Assert rst for one cycle after the 2nd data word is written in scenario 1.
   - All outputs are 0 next cycle; state is IDLE; memory 0x0100–0x0101 still hold 0x1234 and 0xABCD.
   - A new start with the full stream then completes normally.
   - A start pulse while busy has no effect.

Source files
------------

// File: rtl/risc16_mem_loader.sv
// Boot-time program loader for the RiSC16 word memory.
// Takes a byte stream (length word, data words, checksum word, all high byte
// first), writes the data words sequentially from BASE_ADDR and checks a
// trailing additive checksum. busy stays high for the whole load so the core
// can be held in reset until done.
module risc16_mem_loader #(
    parameter int WORD_LENGTH = 16,
    parameter int MEM_SIZE    = 65536,
    parameter int BASE_ADDR   = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [7:0]             in_byte,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WORD_LENGTH-1:0] mem_address,
    output logic [WORD_LENGTH-1:0] mem_data_out,
    output logic                   mem_write_en,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [WORD_LENGTH-1:0] words_written
);

    typedef enum logic [3:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO,
        S_WRITE, S_CHK_HI, S_CHK_LO, S_DONE
    } state_t;

    // Largest length that still fits between BASE_ADDR and the top of memory.
    localparam logic [31:0]            LEN_LIMIT = 32'(MEM_SIZE - BASE_ADDR);
    localparam logic [WORD_LENGTH-1:0] BASE      = WORD_LENGTH'(BASE_ADDR);

    state_t                 state, state_nxt;
    logic [WORD_LENGTH-1:0] len;
    logic [WORD_LENGTH-1:0] checksum;
    logic [7:0]             hi_byte;
    logic                   accept;
    logic [31:0]            len_in;
    logic                   last_word;

    assign accept    = in_valid && in_ready;
    // Full length as it completes in LEN_LO, widened so the bound check
    // cannot wrap.
    assign len_in    = {16'd0, len[15:8], in_byte};
    assign last_word = (words_written + 16'd1) == len;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode plus the state-derived handshake/status outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = S_LEN_HI;
            end
            S_LEN_HI: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = S_LEN_LO;
            end
            S_LEN_LO: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (len_in > LEN_LIMIT)  state_nxt = S_DONE;
                    else if (len_in == 32'd0) state_nxt = S_CHK_HI;
                    else                      state_nxt = S_DATA_HI;
                end
            end
            S_DATA_HI: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = S_DATA_LO;
            end
            S_DATA_LO: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = S_WRITE;
            end
            S_WRITE: state_nxt = last_word ? S_CHK_HI : S_DATA_HI;
            S_CHK_HI: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = S_CHK_LO;
            end
            S_CHK_LO: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = S_DONE;
            end
            S_DONE: begin
                busy = 1'b0;
                done = 1'b1;
                if (start) state_nxt = S_LEN_HI;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: length capture, word assembly, registered memory port,
    // word counter and checksum accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            len           <= '0;
            hi_byte       <= '0;
            checksum      <= '0;
            words_written <= '0;
            mem_address   <= '0;
            mem_data_out  <= '0;
            mem_write_en  <= 1'b0;
            error         <= 1'b0;
        end else begin
            mem_write_en <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        words_written <= '0;
                        checksum      <= '0;
                        error         <= 1'b0;
                    end
                end
                S_LEN_HI: if (accept) len[15:8] <= in_byte;
                S_LEN_LO: begin
                    if (accept) begin
                        len[7:0] <= in_byte;
                        if (len_in > LEN_LIMIT) error <= 1'b1;
                    end
                end
                S_DATA_HI, S_CHK_HI: if (accept) hi_byte <= in_byte;
                // Present the write one cycle ahead so the memory sees stable
                // address/data for the whole WRITE cycle.
                S_DATA_LO: begin
                    if (accept) begin
                        mem_write_en <= 1'b1;
                        mem_address  <= BASE + words_written;
                        mem_data_out <= {hi_byte, in_byte};
                    end
                end
                S_WRITE: begin
                    words_written <= words_written + 16'd1;
                    checksum      <= checksum + mem_data_out;
                end
                S_CHK_LO: if (accept) error <= ({hi_byte, in_byte} != checksum);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_risc16_mem_loader.sv
// Bench for risc16_mem_loader: two instances (large memory at base 0x0100,
// tiny 16-word memory at base 14) share the byte stream; each scenario task
// drives a stream and compares against expectations derived from the
// stream contents with plain arithmetic.
module tb_risc16_mem_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       start_a = 1'b0, start_b = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_byte = 8'h00;

    logic        rdy_a, we_a, busy_a, done_a, err_a;
    logic [15:0] addr_a, data_a, ww_a;
    logic        rdy_b, we_b, busy_b, done_b, err_b;
    logic [15:0] addr_b, data_b, ww_b;

    risc16_mem_loader #(.WORD_LENGTH(16), .MEM_SIZE(65536), .BASE_ADDR(16'h0100)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .in_byte(in_byte), .in_valid(in_valid),
        .in_ready(rdy_a), .mem_address(addr_a), .mem_data_out(data_a),
        .mem_write_en(we_a), .busy(busy_a), .done(done_a), .error(err_a),
        .words_written(ww_a));

    risc16_mem_loader #(.WORD_LENGTH(16), .MEM_SIZE(16), .BASE_ADDR(14)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .in_byte(in_byte), .in_valid(in_valid),
        .in_ready(rdy_b), .mem_address(addr_b), .mem_data_out(data_b),
        .mem_write_en(we_b), .busy(busy_b), .done(done_b), .error(err_b),
        .words_written(ww_b));

    int checks = 0;
    int errors = 0;
    bit sel = 1'b0;   // 0 selects dut_a, 1 selects dut_b

    logic        rdy_s, busy_s, done_s, err_s;
    logic [15:0] ww_s;
    assign rdy_s  = sel ? rdy_b  : rdy_a;
    assign busy_s = sel ? busy_b : busy_a;
    assign done_s = sel ? done_b : done_a;
    assign err_s  = sel ? err_b  : err_a;
    assign ww_s   = sel ? ww_b   : ww_a;

    // Observed memory writes (both instances; only one is ever active).
    logic [15:0] wr_addr_q[$];
    logic [15:0] wr_data_q[$];
    logic [15:0] mem_a[int];
    int          wr_rdy_bad = 0;
    int          acc_cnt = 0;

    // Record each write-enable cycle at the memory's negedge write point.
    always @(negedge clk) begin
        if (we_a) begin
            wr_addr_q.push_back(addr_a);
            wr_data_q.push_back(data_a);
            mem_a[int'(addr_a)] = data_a;
            if (rdy_a) wr_rdy_bad++;
        end
        if (we_b) begin
            wr_addr_q.push_back(addr_b);
            wr_data_q.push_back(data_b);
            if (rdy_b) wr_rdy_bad++;
        end
    end

    // Count bytes actually consumed by the selected instance.
    always @(posedge clk) if (!rst && in_valid && rdy_s) acc_cnt++;

    logic [7:0] stim[$];

    task automatic pulse_start(input bit b_sel);
        if (b_sel) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge following the accept.
    // With junk set, bytes presented while not ready are random garbage.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit junk);
        int guard = 0;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        while (!rdy_s && guard < 50) begin
            in_valid = 1'b1;
            in_byte  = junk ? 8'($urandom) : b;
            @(negedge clk);
            guard++;
        end
        checks++;
        if (!rdy_s) begin
            errors++;
            $display("FAIL ready_timeout: in_ready=%0b after %0d cycles, required 1", rdy_s, guard);
        end
        in_valid = 1'b1;
        in_byte  = b;
        @(negedge clk);
    endtask

    // Full load: start, stream, wait for done, compare against expectations
    // derived directly from the byte stream. A stray start pulse is inserted
    // before byte index start_at (negative: none).
    task automatic run_load(input string nm, input logic [7:0] bs[$], input int gapmax,
                            input bit junk, input bit b_sel, input int start_at);
        int          wb, ab, guard, base, msize, len, exp_ww, nwr;
        logic        exp_err;
        logic [15:0] sum, w, chk;
        logic [15:0] ea[$];
        logic [15:0] ed[$];
        sel   = b_sel;
        base  = b_sel ? 14 : 'h100;
        msize = b_sel ? 16 : 65536;

        len = int'({bs[0], bs[1]});
        sum = 16'h0;
        if (len > msize - base) begin
            exp_err = 1'b1;
            exp_ww  = 0;
        end else begin
            for (int i = 0; i < len; i++) begin
                w = {bs[2 + 2*i], bs[3 + 2*i]};
                ea.push_back(16'(base + i));
                ed.push_back(w);
                sum = sum + w;
            end
            chk     = {bs[2 + 2*len], bs[3 + 2*len]};
            exp_err = (chk != sum);
            exp_ww  = len;
        end

        wb = wr_addr_q.size();
        ab = acc_cnt;
        pulse_start(b_sel);
        checks++;
        if (busy_s !== 1'b1 || done_s !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_after_start: busy=%0b done=%0b, required 1/0", nm, busy_s, done_s);
        end
        for (int i = 0; i < bs.size(); i++) begin
            if (i == start_at) begin
                in_valid = 1'b0;
                pulse_start(b_sel);
            end
            send_byte(bs[i], gapmax > 0 ? int'($urandom_range(0, gapmax)) : 0, junk);
        end
        in_valid = 1'b0;
        guard = 0;
        while (!done_s && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        repeat (2) @(negedge clk);

        checks++;
        if (done_s !== 1'b1 || busy_s !== 1'b0) begin
            errors++;
            $display("FAIL %s_done: done=%0b busy=%0b, required 1/0", nm, done_s, busy_s);
        end
        checks++;
        if (err_s !== exp_err) begin
            errors++;
            $display("FAIL %s_error: got %0b, required %0b", nm, err_s, exp_err);
        end
        checks++;
        if (ww_s !== 16'(exp_ww)) begin
            errors++;
            $display("FAIL %s_words_written: got %0d, required %0d", nm, ww_s, exp_ww);
        end
        nwr = wr_addr_q.size() - wb;
        checks++;
        if (nwr != ea.size()) begin
            errors++;
            $display("FAIL %s_write_count: got %0d pulses, required %0d", nm, nwr, ea.size());
        end else begin
            for (int i = 0; i < nwr; i++) begin
                checks++;
                if (wr_addr_q[wb + i] !== ea[i] || wr_data_q[wb + i] !== ed[i]) begin
                    errors++;
                    $display("FAIL %s_write%0d: got %h@%h, required %h@%h", nm, i,
                             wr_data_q[wb + i], wr_addr_q[wb + i], ed[i], ea[i]);
                end
            end
        end
        checks++;
        if (acc_cnt - ab != bs.size()) begin
            errors++;
            $display("FAIL %s_bytes_accepted: got %0d, required %0d", nm, acc_cnt - ab, bs.size());
        end
        checks++;
        if (wr_rdy_bad != 0) begin
            errors++;
            $display("FAIL %s_ready_in_write: %0d write cycles had in_ready=1, required 0", nm, wr_rdy_bad);
        end
    endtask

    task automatic set_spec_stream(input logic [7:0] chk_lo);
        stim = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hBE, chk_lo};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({rdy_a, we_a, busy_a, done_a, err_a, addr_a, data_a, ww_a} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_a: rdy=%0b we=%0b busy=%0b done=%0b err=%0b addr=%h data=%h ww=%h, required all 0",
                     rdy_a, we_a, busy_a, done_a, err_a, addr_a, data_a, ww_a);
        end
        checks++;
        if ({rdy_b, we_b, busy_b, done_b, err_b, ww_b} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_b: rdy=%0b we=%0b busy=%0b done=%0b err=%0b ww=%h, required all 0",
                     rdy_b, we_b, busy_b, done_b, err_b, ww_b);
        end
    endtask

    task automatic test_normal();
        set_spec_stream(8'h02);
        run_load("normal", stim, 0, 1'b0, 1'b0, -1);
    endtask

    task automatic test_bad_checksum();
        set_spec_stream(8'h03);
        run_load("badchk", stim, 0, 1'b0, 1'b0, -1);
    endtask

    task automatic test_zero_length();
        stim = '{8'h00, 8'h00, 8'h00, 8'h00};
        run_load("zero", stim, 0, 1'b0, 1'b0, -1);
        stim = '{8'h00, 8'h00, 8'h00, 8'h01};
        run_load("zero_badchk", stim, 0, 1'b0, 1'b0, -1);
    endtask

    task automatic test_overflow();
        logic [15:0] w0, w1, s;
        stim = '{8'h00, 8'h03};
        run_load("overflow", stim, 0, 1'b0, 1'b1, -1);
        w0 = 16'($urandom);
        w1 = 16'($urandom);
        s  = w0 + w1;
        stim = '{8'h00, 8'h02, w0[15:8], w0[7:0], w1[15:8], w1[7:0], s[15:8], s[7:0]};
        run_load("fill_top", stim, 0, 1'b0, 1'b1, -1);
        sel = 1'b0;
    endtask

    task automatic test_gaps();
        mem_a.delete();
        set_spec_stream(8'h02);
        run_load("gaps", stim, 3, 1'b1, 1'b0, -1);
        checks++;
        if (mem_a[256] !== 16'h1234 || mem_a[257] !== 16'hABCD || mem_a[258] !== 16'h0001) begin
            errors++;
            $display("FAIL gaps_memory: got %h %h %h, required 1234 abcd 0001",
                     mem_a[256], mem_a[257], mem_a[258]);
        end
    endtask

    task automatic test_reset_restart();
        mem_a.delete();
        sel = 1'b0;
        set_spec_stream(8'h02);
        pulse_start(1'b0);
        for (int i = 0; i < 6; i++) send_byte(stim[i], 0, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (ww_a !== 16'd2) begin
            errors++;
            $display("FAIL restart_pre_reset_count: words_written=%0d, required 2", ww_a);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({rdy_a, we_a, busy_a, done_a, err_a, addr_a, data_a, ww_a} !== '0) begin
            errors++;
            $display("FAIL restart_reset_outputs: rdy=%0b we=%0b busy=%0b done=%0b err=%0b addr=%h data=%h ww=%h, required all 0",
                     rdy_a, we_a, busy_a, done_a, err_a, addr_a, data_a, ww_a);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || rdy_a !== 1'b0) begin
            errors++;
            $display("FAIL restart_idle_hold: busy=%0b done=%0b rdy=%0b, required 0/0/0", busy_a, done_a, rdy_a);
        end
        checks++;
        if (mem_a.size() != 2 || mem_a[256] !== 16'h1234 || mem_a[257] !== 16'hABCD) begin
            errors++;
            $display("FAIL restart_memory_kept: %0d words, got %h %h, required 2 words 1234 abcd",
                     mem_a.size(), mem_a[256], mem_a[257]);
        end
        // Fresh load with a stray start pulse mid-stream, which must be ignored.
        run_load("restart", stim, 0, 1'b0, 1'b0, 4);
    endtask

    task automatic test_random();
        logic [15:0] len, w, sum, chk;
        for (int it = 0; it < 10; it++) begin
            stim.delete();
            sum = 16'h0;
            if (it == 9) len = 16'hFF01 + 16'($urandom_range(0, 254));
            else         len = 16'($urandom_range(0, 5));
            stim.push_back(len[15:8]);
            stim.push_back(len[7:0]);
            if (it != 9) begin
                for (int i = 0; i < int'(len); i++) begin
                    w = 16'($urandom);
                    stim.push_back(w[15:8]);
                    stim.push_back(w[7:0]);
                    sum = sum + w;
                end
                chk = ($urandom_range(0, 2) == 0) ? sum + 16'($urandom_range(1, 65535)) : sum;
                stim.push_back(chk[15:8]);
                stim.push_back(chk[7:0]);
            end
            run_load($sformatf("random%0d", it), stim, int'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), 1'b0, -1);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_bad_checksum();
        test_zero_length();
        test_overflow();
        test_gaps();
        test_reset_restart();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
